irq_ctrl: RTL and testbench

- Multi-source interrupt controller in front of the CP0 block.
- Detects rising edges on N external sources and latches them as pending, subject to a software-writable mask.
- Picks the highest-priority unmasked source, raises one interrupt request line into CP0's external-interrupt input, and holds it until the core takes the interrupt.
- Blocks further requests until ERET, and exposes the cause index for the handler to read.

---
 rtl/cp0_defs.sv | 25 ++
 rtl/prio_enc.sv | 25 ++
 rtl/irq_ctrl.sv | 138 +++++++++++++
 tb/tb_irq_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cp0_defs.sv
// Shared CP0 definitions: interrupt FSM encodings, CP0 register indices
// and EXE-stage oper codes used by the interrupt front end.
package cp0_defs;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SVC  = 2'd2
    } irq_state_e;

    localparam logic [4:0] EPCR = 5'd0;
    localparam logic [4:0] EHBR = 5'd1;

    typedef enum logic [2:0] {
        EXE_NOP      = 3'd0,
        EXE_CP0_MFC0 = 3'd1,
        EXE_CP0_MTC0 = 3'd2,
        EXE_CP0_ERET = 3'd3
    } cp0_oper_e;

    function automatic logic is_eret(input cp0_oper_e oper);
        return (oper == EXE_CP0_ERET);
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder: index 0 wins.
module prio_enc #(
    parameter int W     = 8,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    // Scan from the top down so the lowest set bit is written last.
    always_comb begin
        index = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IDX_W'(i);
            end else begin
                index = index;
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller feeding CP0's external-interrupt input:
// edge-latched pending bits, mask, fixed priority and a REQ/SERVICE handshake.
import cp0_defs::*;

module irq_ctrl #(
    parameter int N_SRC   = 8,
    parameter int CAUSE_W = $clog2(N_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   irq_src,
    input  logic               mask_we,
    input  logic [N_SRC-1:0]   mask_wdata,
    output logic [N_SRC-1:0]   mask,
    output logic [N_SRC-1:0]   pend,
    input  logic               eret,
    input  logic               irq_taken,
    output logic               irq_out,
    output logic [CAUSE_W-1:0] cause,
    output logic               cause_valid,
    output logic               busy
);

    logic [N_SRC-1:0]   prev_src_r;
    logic [N_SRC-1:0]   pend_r;
    logic [N_SRC-1:0]   mask_r;
    irq_state_e         state_r;
    irq_state_e         state_nxt_s;
    logic [CAUSE_W-1:0] cause_r;
    logic [CAUSE_W-1:0] cause_nxt_s;
    logic               irq_out_r;
    logic               cause_valid_r;
    logic               busy_r;

    logic [N_SRC-1:0]   rise_s;
    logic [N_SRC-1:0]   clr_s;
    logic [N_SRC-1:0]   active_s;
    logic [CAUSE_W-1:0] sel_s;
    logic               any_s;

    assign rise_s   = irq_src & ~prev_src_r;
    assign active_s = pend_r & mask_r;

    prio_enc #(
        .W     (N_SRC),
        .IDX_W (CAUSE_W)
    ) u_prio_enc (
        .vec   (active_s),
        .index (sel_s),
        .any   (any_s)
    );

    // The pending bit of the cause being accepted is cleared on take.
    always_comb begin
        clr_s = '0;
        if ((state_r == IRQ_REQ) && irq_taken) begin
            clr_s[cause_r] = 1'b1;
        end else begin
            clr_s = '0;
        end
    end

    // Next-state logic; cause is latched only when leaving IDLE.
    always_comb begin
        state_nxt_s = state_r;
        cause_nxt_s = cause_r;
        case (state_r)
            IRQ_IDLE: begin
                if (any_s) begin
                    state_nxt_s = IRQ_REQ;
                    cause_nxt_s = sel_s;
                end else begin
                    state_nxt_s = IRQ_IDLE;
                end
            end
            IRQ_REQ: begin
                if (irq_taken) begin
                    state_nxt_s = IRQ_SVC;
                end else if (!mask_r[cause_r]) begin
                    state_nxt_s = IRQ_IDLE;
                end else begin
                    state_nxt_s = IRQ_REQ;
                end
            end
            IRQ_SVC: begin
                if (eret) begin
                    state_nxt_s = IRQ_IDLE;
                end else begin
                    state_nxt_s = IRQ_SVC;
                end
            end
            default: begin
                state_nxt_s = IRQ_IDLE;
                cause_nxt_s = '0;
            end
        endcase
    end

    // Source history, pending and mask registers; a new edge beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_src_r <= '0;
            pend_r     <= '0;
            mask_r     <= {N_SRC{1'b1}};
        end else begin
            prev_src_r <= irq_src;
            pend_r     <= (pend_r & ~clr_s) | rise_s;
            if (mask_we) begin
                mask_r <= mask_wdata;
            end
        end
    end

    // FSM state plus outputs decoded from the next state so they are flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IRQ_IDLE;
            cause_r       <= '0;
            irq_out_r     <= 1'b0;
            cause_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cause_r       <= cause_nxt_s;
            irq_out_r     <= (state_nxt_s == IRQ_REQ);
            cause_valid_r <= (state_nxt_s != IRQ_IDLE);
            busy_r        <= (state_nxt_s == IRQ_SVC);
        end
    end

    assign mask        = mask_r;
    assign pend        = pend_r;
    assign cause       = cause_r;
    assign irq_out     = irq_out_r;
    assign cause_valid = cause_valid_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed test-plan steps followed by random traffic, every cycle checked
// against a behavioural model of the interrupt controller.
module tb_irq_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq_src = '0;
    logic         mask_we = 1'b0;
    logic [N-1:0] mask_wdata = '0;
    logic [N-1:0] mask;
    logic [N-1:0] pend;
    logic         eret = 1'b0;
    logic         irq_taken = 1'b0;
    logic         irq_out;
    logic [2:0]   cause;
    logic         cause_valid;
    logic         busy;

    int checks = 0;
    int failures = 0;

    // model: 0 = idle, 1 = requesting, 2 = in handler
    bit [N-1:0] m_prev, m_pend, m_mask;
    int         m_st, m_cause;

    irq_ctrl #(.N_SRC(N), .CAUSE_W(3)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask(mask), .pend(pend), .eret(eret),
        .irq_taken(irq_taken), .irq_out(irq_out), .cause(cause),
        .cause_valid(cause_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit [N-1:0] nxt;
        int sel;
        if (rst) begin
            m_prev = '0; m_pend = '0; m_mask = '1; m_st = 0; m_cause = 0;
        end else begin
            sel = -1;
            for (int i = 0; i < N; i++)
                if (sel < 0 && m_pend[i] && m_mask[i]) sel = i;
            nxt = m_pend;
            if (m_st == 1 && irq_taken) nxt[m_cause] = 1'b0;
            for (int i = 0; i < N; i++)
                if (irq_src[i] && !m_prev[i]) nxt[i] = 1'b1;
            if (m_st == 0) begin
                if (sel >= 0) begin m_st = 1; m_cause = sel; end
            end else if (m_st == 1) begin
                if (irq_taken) m_st = 2;
                else if (!m_mask[m_cause]) m_st = 0;
            end else begin
                if (eret) m_st = 0;
            end
            m_pend = nxt;
            m_prev = irq_src;
            if (mask_we) m_mask = mask_wdata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("irq_out", 32'(irq_out), 32'(m_st == 1));
        chk("cause_valid", 32'(cause_valid), 32'(m_st != 0));
        chk("busy", 32'(busy), 32'(m_st == 2));
        chk("cause", 32'(cause), 32'(m_cause));
        chk("pend", 32'(pend), 32'(m_pend));
        chk("mask", 32'(mask), 32'(m_mask));
    endtask

    initial begin
        // reset state
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("rst_mask", 32'(mask), 32'h0000_00FF);
        chk("rst_irq", 32'(irq_out), 32'h0);

        // single source, latency and no re-request while held
        irq_src = 8'h04; tick(); tick();
        chk("s_irq", 32'(irq_out), 32'h1);
        chk("s_cause", 32'(cause), 32'h2);
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        chk("s_pend", 32'(pend), 32'h0);
        chk("s_busy", 32'(busy), 32'h1);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("s_eret_irq", 32'(irq_out), 32'h0);
        chk("s_eret_cv", 32'(cause_valid), 32'h0);
        tick(); tick(); tick();
        chk("s_held", 32'(irq_out), 32'h0);

        // priority and one idle cycle between handlers
        irq_src = 8'h00; tick();
        irq_src = 8'h22; tick(); tick();
        chk("p_cause1", 32'(cause), 32'h1);
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        chk("p_idle", 32'(cause_valid), 32'h0);
        tick();
        chk("p_irq5", 32'(irq_out), 32'h1);
        chk("p_cause5", 32'(cause), 32'h5);
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;

        // masking
        irq_src = 8'h00; mask_we = 1'b1; mask_wdata = 8'hFE; tick(); mask_we = 1'b0;
        irq_src = 8'h01; tick(); tick(); tick();
        chk("m_pend", 32'(pend), 32'h01);
        chk("m_irq", 32'(irq_out), 32'h0);
        mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0; tick();
        chk("m_irq_on", 32'(irq_out), 32'h1);
        chk("m_cause", 32'(cause), 32'h0);
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        irq_src = 8'h00; tick();

        // withdraw by masking while requesting
        irq_src = 8'h08; tick(); tick();
        chk("w_cause", 32'(cause), 32'h3);
        mask_we = 1'b1; mask_wdata = 8'hF7; tick(); mask_we = 1'b0; tick();
        chk("w_irq", 32'(irq_out), 32'h0);
        chk("w_pend3", 32'(pend[3]), 32'h1);
        mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0; tick();
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        irq_src = 8'h00; tick();

        // set wins over clear in the take cycle
        irq_src = 8'h04; tick(); tick();
        irq_src = 8'h00; tick();
        irq_src = 8'h04; irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        chk("c_pend2", 32'(pend[2]), 32'h1);
        eret = 1'b1; tick(); eret = 1'b0; tick();
        chk("c_irq", 32'(irq_out), 32'h1);
        chk("c_cause", 32'(cause), 32'h2);
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;

        // reset in the middle of a handler
        irq_src = 8'h00; tick();
        irq_src = 8'h01; tick(); tick();
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        irq_src = 8'h31; tick();
        chk("r_pend", 32'(pend), 32'h30);
        chk("r_busy", 32'(busy), 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("r_pend0", 32'(pend), 32'h0);
        chk("r_mask", 32'(mask), 32'hFF);
        chk("r_irq", 32'(irq_out), 32'h0);
        chk("r_busy0", 32'(busy), 32'h0);
        chk("r_cause", 32'(cause), 32'h0);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            irq_src    = irq_src ^ 8'($urandom & $urandom & $urandom);
            irq_taken  = ($urandom % 3 == 0);
            eret       = ($urandom % 4 == 0);
            mask_we    = ($urandom % 16 == 0);
            mask_wdata = 8'($urandom);
            rst        = ($urandom % 200 == 0);
            tick();
        end
        rst = 1'b0; irq_taken = 1'b0; eret = 1'b0; mask_we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
